// File: rtl/wave_capture_if.sv
// Capture-side bundle: sample/frame strobes in, RAM write port and display-half select out.
interface wave_capture_if;
  logic        new_sample;
  logic [15:0] sample;
  logic        new_frame;
  logic        write_en;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        capture_busy;

  modport master (
    output new_sample, sample, new_frame,
    input  write_en, write_address, write_sample, read_index, capture_busy
  );

  modport slave (
    input  new_sample, sample, new_frame,
    output write_en, write_address, write_sample, read_index, capture_busy
  );
endinterface

// File: rtl/wave_capture.sv
// Zero-crossing triggered 256-sample waveform capture into a double-buffered RAM; writes are
// combinational with new_sample (0 cycles), no backpressure. Optional forced trigger: WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture #(
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  wave_capture_if.slave bus
);

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    ACTIVE = 2'b01,
    WAIT   = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] slot;
  logic       prev_neg;
  logic       disp_half;
  logic       timeout_hit;
  logic       trigger;
  logic       active_write;

  assign trigger      = (state == ARMED) && bus.new_sample &&
                        ((prev_neg && !bus.sample[15]) || timeout_hit);
  assign active_write = (state == ACTIVE) && bus.new_sample;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
  logic [TW-1:0] timeout_cnt;

  assign timeout_hit = bus.new_sample && (timeout_cnt == TW'(TIMEOUT_SAMPLES));

  // Held at zero outside ARMED, so it always starts fresh on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_cnt <= '0;
    end else if (state != ARMED || trigger) begin
      timeout_cnt <= '0;
    end else if (bus.new_sample) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_SAMPLES;
  assign timeout_hit = 1'b0;
`endif

  // Low sample byte is below display resolution.
  logic unused_sample_lsbs;
  assign unused_sample_lsbs = &{1'b0, bus.sample[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARMED:   if (trigger) state_nxt = ACTIVE;
      ACTIVE:  if (active_write && slot == 8'hFF) state_nxt = WAIT;
      WAIT:    if (bus.new_frame) state_nxt = ARMED;
      default: state_nxt = ARMED;
    endcase
  end

  always_comb begin
    bus.write_en     = reset && (trigger || active_write);
    bus.capture_busy = (state == ACTIVE) || (state == WAIT);
  end

  // Slot saturates at 255 on the last write so it never wraps while leaving ACTIVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot      <= 8'd0;
      prev_neg  <= 1'b0;
      disp_half <= 1'b0;
    end else begin
      if (bus.new_sample) begin
        prev_neg <= bus.sample[15];
      end
      if (trigger) begin
        slot <= 8'd1;
      end else if (active_write && slot != 8'hFF) begin
        slot <= slot + 8'd1;
      end else if ((state == WAIT && bus.new_frame) ||
                   (state != ARMED && state != ACTIVE && state != WAIT)) begin
        slot <= 8'd0;
      end
      if (state == WAIT && bus.new_frame) begin
        disp_half <= ~disp_half;
      end
    end
  end

  assign bus.write_address = {~disp_half, slot};
  assign bus.write_sample  = {~bus.sample[15], bus.sample[14:8]};
  assign bus.read_index    = disp_half;

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter: TIMEOUT_SAMPLES, default 1024, number of samples counted in ARMED before a forced trigger (used only with WAVE_CAPTURE_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 new_sample  input  1  one-cycle strobe; sample is valid this cycle.
REQ-005 sample  input  16  signed two's-complement audio sample.
REQ-006 new_frame  input  1  one-cycle strobe at the display frame boundary.
REQ-007 write_en  output  1  write strobe to the 1-write/2-read waveform RAM.
REQ-008 write_address  output  9  RAM write address, formed as {write half, slot[7:0]}.
REQ-009 write_sample  output  8  unsigned display value written to the RAM.
REQ-010 read_index  output  1  RAM half the display reads; the capture writes the other half.
REQ-011 capture_busy  output  1  high in states ACTIVE and WAIT.

Function
REQ-012 States: ARMED, ACTIVE, WAIT; 2-bit encoding; unused codes return to ARMED on the next clk.
REQ-013 Previous-sample register: on every new_sample, store sample[15] as prev_neg.
- This update happens in all states.
REQ-014 Trigger: new_sample=1 in ARMED with prev_neg=1 and sample[15]=0 (rising zero crossing).
REQ-015 On trigger, in the same cycle:
- write_en=1, write_address={~read_index, 8'd0}.
- Slot counter becomes 1; next state ACTIVE.
REQ-016 In ACTIVE, each new_sample writes slot N (write_address={~read_index, N}) and increments the slot counter.
- The write at slot 255 moves the state to WAIT.
- Exactly 256 writes occur per capture.
REQ-017 write_sample = {~sample[15], sample[14:8]}, which is sample[15:8] offset by +128.
- Combinational from sample; the value is don't-care when write_en=0.
REQ-018 write_en is combinational: high only in the cycle of an accepted new_sample in the trigger or ACTIVE condition.
- Zero added latency from new_sample.
REQ-019 new_sample in WAIT is dropped: no write, slot counter unchanged.
REQ-020 In WAIT, new_frame=1:
- read_index toggles on the next clk edge.
- Slot counter clears; next state ARMED.
REQ-021 new_frame in ARMED or ACTIVE is ignored; read_index changes only per REQ-020.
- The displayed half is never the half being written.
REQ-022 Simultaneous new_frame and new_sample in WAIT: the flip occurs and the sample is dropped.
- The next trigger evaluation starts from the following new_sample.
REQ-023 Slot counter is 8 bits and is never allowed to wrap inside ACTIVE.

Reset
REQ-024 Reset asynchronously forces:
- state=ARMED, slot counter=0, prev_neg=0, read_index=0, timeout counter=0.
- write_en=0, capture_busy=0, write_address=9'h100.
REQ-025 Reset asserted mid-capture abandons the partial capture.
- No write occurs while reset=0.
- The first write after release requires a fresh trigger.

Configuration
REQ-026 Macro WAVE_CAPTURE_TIMEOUT_EN defined:
- A counter increments on each new_sample in ARMED that is not a trigger.
- When it reaches TIMEOUT_SAMPLES, that new_sample is treated as a trigger.
- The counter clears on entering ARMED and on any trigger.
REQ-027 Macro WAVE_CAPTURE_TIMEOUT_EN undefined:
- No timeout counter exists.
- ARMED waits indefinitely for a zero crossing.

Verification
REQ-028 Reset then one period of a sine wave: first write at the first negative-to-nonnegative sample, address 0x100.
- 256 consecutive writes to 0x100..0x1FF; capture_busy=1 from the trigger through WAIT.
REQ-029 Sample 16'h8000 written -> write_sample=8'h00.
- 16'h0000 -> 8'h80; 16'h7FFF -> 8'hFF.
REQ-030 In WAIT, 10 new_sample strobes then new_frame: no writes, read_index 0->1.
- The next capture writes 0x000..0x0FF.
REQ-031 new_frame pulsed during ACTIVE at slot 100: read_index unchanged, capture completes all 256 slots.
REQ-032 reset pulled low at slot 50: outputs reach reset values immediately; after release, no write until a new zero crossing.
REQ-033 With WAVE_CAPTURE_TIMEOUT_EN and TIMEOUT_SAMPLES=1024, a constant positive input: the forced trigger writes address 0x100 on the 1025th new_sample.
- Without the macro, no write occurs within 5000 samples.
